trip_ctrl: RTL

Trip sequencer for the taxi meter. Turns the driver keys, the red-light sensor and the wheel-pulse sensor into the control and distance inputs of the fare calculator. Owns the trip state machine (idle / running / waiting at red / paused / finished) and the kilometre counter, and generates the one-cycle waiting-time tick the fare calculator edge-detects to add its waiting surcharge.

---
 rtl/trip_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/trip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trip_ctrl
//  Purpose  : Taxi-meter trip sequencer. Converts driver keys, the red-light
//             sensor and wheel pulses into fare-calculator controls: trip
//             state machine, kilometre counter and the waiting-time tick.
//  Ports    : clk, reset (async, active-high)
//             key_start/key_pause/key_stop : single-cycle key pulses
//             red_light : level, cab waiting at a red light
//             wheel_pulse : one pulse per wheel revolution
//             start/waitL/pause/trip_done : state decodes
//             time_enable : one-cycle waiting tick
//             distance : km this trip, saturating at 1023
//             fee_clr : one-cycle pulse when a trip begins
//             state : IDLE=0 RUN=1 WAIT=2 PAUSE=3 DONE=4
//  Revision : 1.0 - initial release
// ============================================================================
module trip_ctrl #(
  parameter int unsigned WHEEL_PER_KM = 8,     // 1..255
  parameter int unsigned WAIT_CYCLES  = 1000   // 2..2^24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start,
  input  logic       key_pause,
  input  logic       key_stop,
  input  logic       red_light,
  input  logic       wheel_pulse,
  output logic       start,
  output logic       waitL,
  output logic       pause,
  output logic       time_enable,
  output logic [9:0] distance,
  output logic       fee_clr,
  output logic       trip_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_WAIT  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  C_WHEEL_LAST = 8'(WHEEL_PER_KM - 1);
  localparam logic [23:0] C_WAIT_LAST  = 24'(WAIT_CYCLES - 1);
  localparam logic [9:0]  C_DIST_MAX   = 10'd1023;

  state_t      state_q, state_d;
  logic [7:0]  wheel_q, wheel_d;
  logic [9:0]  dist_q,  dist_d;
  logic [23:0] wcnt_q,  wcnt_d;
  logic        tick_d,  fee_d;
  logic        tick_q,  fee_q;
  logic        start_q, waitl_q, pause_q, done_q;

  always_comb begin
    state_d = state_q;
    wheel_d = wheel_q;
    dist_d  = dist_q;
    wcnt_d  = '0;       // counter only lives inside WAIT; leaving drops it
    tick_d  = 1'b0;
    fee_d   = 1'b0;

    // Waiting counter follows the registered state, so a wrap on the
    // edge that leaves WAIT still produces its tick.
    if (state_q == S_WAIT) begin
      if (wcnt_q == C_WAIT_LAST) begin
        tick_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 24'd1;
      end
    end

    // Pulses count on any edge where the registered state is RUN, including
    // the edge that moves to WAIT/PAUSE/DONE.
    if ((state_q == S_RUN) && wheel_pulse) begin
      if (wheel_q == C_WHEEL_LAST) begin
        wheel_d = '0;
        if (dist_q != C_DIST_MAX) begin
          dist_d = dist_q + 10'd1;
        end
      end else begin
        wheel_d = wheel_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (key_start) begin
          state_d = S_RUN;
          wheel_d = '0;
          dist_d  = '0;
          wcnt_d  = '0;
          fee_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (key_stop)       state_d = S_DONE;
        else if (key_pause) state_d = S_PAUSE;
        else if (red_light) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (key_stop)        state_d = S_DONE;
        else if (key_pause)  state_d = S_PAUSE;
        else if (!red_light) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (key_stop)       state_d = S_DONE;
        else if (key_pause) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and decoded outputs; decodes are taken from the next
  // state so they always match the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wheel_q <= '0;
      dist_q  <= '0;
      wcnt_q  <= '0;
      tick_q  <= 1'b0;
      fee_q   <= 1'b0;
      start_q <= 1'b0;
      waitl_q <= 1'b0;
      pause_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wheel_q <= wheel_d;
      dist_q  <= dist_d;
      wcnt_q  <= wcnt_d;
      tick_q  <= tick_d;
      fee_q   <= fee_d;
      start_q <= (state_d == S_RUN) || (state_d == S_WAIT) || (state_d == S_PAUSE);
      waitl_q <= (state_d == S_WAIT);
      pause_q <= (state_d == S_PAUSE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign start       = start_q;
  assign waitL       = waitl_q;
  assign pause       = pause_q;
  assign trip_done   = done_q;
  assign time_enable = tick_q;
  assign fee_clr     = fee_q;
  assign distance    = dist_q;
  assign state       = state_q;

endmodule
`default_nettype wire
